// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction, config, debug and write-back bundle for alu_sequencer
interface alu_sequencer_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic        busy;
  logic [15:0] retired;

  modport master (
    output instr_valid, instr, cfg_we, cfg_addr, cfg_data, dbg_addr,
    input  instr_ready, dbg_data, wb_en, wb_addr, wb_data, illegal, busy, retired
  );

  modport slave (
    input  instr_valid, instr, cfg_we, cfg_addr, cfg_data, dbg_addr,
    output instr_ready, dbg_data, wb_en, wb_addr, wb_data, illegal, busy, retired
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - four-state R-type ALU sequencer over a 32x32 register file
module alu_sequencer #(
  parameter int unsigned ZERO_REG_RO = 1
) (
  input  logic           clk,
  input  logic           rst,
  alu_sequencer_if.slave bus
);
  localparam bit ZRO = (ZERO_REG_RO != 0);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t      state_q;
  logic [31:0] instr_q;
  logic [31:0] a_q, b_q;
  logic [31:0] regs_q [32];
  logic        wb_en_q, illegal_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;
  logic [15:0] retired_q;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] rs_val, rt_val;
  logic [31:0] result_d;
  logic        illegal_d;

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign shamt  = instr_q[10:6];
  assign funct  = instr_q[5:0];

  // r0 reads are forced to zero explicitly so the guarantee does not rest on reset alone
  assign rs_val       = (ZRO && rs == 5'd0) ? 32'd0 : regs_q[rs];
  assign rt_val       = (ZRO && rt == 5'd0) ? 32'd0 : regs_q[rt];
  assign bus.dbg_data = (ZRO && bus.dbg_addr == 5'd0) ? 32'd0 : regs_q[bus.dbg_addr];

  always_comb begin
    result_d  = 32'd0;
    illegal_d = 1'b1;
    if (opcode == 6'd0) begin
      case (funct)
        6'b100000: begin result_d = a_q + b_q;    illegal_d = 1'b0; end
        6'b100010: begin result_d = a_q - b_q;    illegal_d = 1'b0; end
        6'b000010: begin result_d = b_q >> shamt; illegal_d = 1'b0; end
        default:   begin result_d = 32'd0;        illegal_d = 1'b1; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      instr_q   <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      wb_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= 32'd0;
      retired_q <= 16'd0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else begin
      wb_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cfg_we && !(ZRO && bus.cfg_addr == 5'd0))
            regs_q[bus.cfg_addr] <= bus.cfg_data;
          if (bus.instr_valid) begin
            instr_q <= bus.instr;
            state_q <= READ;
          end
        end
        READ: begin
          a_q     <= rs_val;
          b_q     <= rt_val;
          state_q <= EXEC;
        end
        EXEC: begin
          // wb_data_q doubles as the result register
          wb_en_q   <= 1'b1;
          illegal_q <= illegal_d;
          wb_addr_q <= rd;
          wb_data_q <= result_d;
          state_q   <= WB;
        end
        WB: begin
          if (!(ZRO && wb_addr_q == 5'd0))
            regs_q[wb_addr_q] <= wb_data_q;
          retired_q <= retired_q + 16'd1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.wb_en       = wb_en_q;
  assign bus.illegal     = illegal_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.retired     = retired_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   accepts;

  alu_sequencer_if bus ();

  alu_sequencer #(.ZERO_REG_RO(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dbg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.dbg_addr = addr;
    #1;
    chk(tag, bus.dbg_data, exp);
  endtask

  task automatic cfg(input logic [4:0] addr, input logic [31:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  // Offers w in IDLE, checks the WB cycle at accept+3 and the register after return to IDLE
  task automatic run(input string tag, input logic [31:0] w, input logic [4:0] rd,
                     input logic [31:0] exp, input logic exp_ill, input logic [15:0] exp_ret);
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    tick();
    bus.instr_valid = 1'b0;
    bus.instr       = $urandom;
    chk({tag, ".busy_read"}, 32'(bus.busy), 32'd1);
    tick();
    tick();
    chk({tag, ".wb_en"},   32'(bus.wb_en),   32'd1);
    chk({tag, ".wb_addr"}, 32'(bus.wb_addr), 32'(rd));
    chk({tag, ".wb_data"}, bus.wb_data,      exp);
    chk({tag, ".illegal"}, 32'(bus.illegal), 32'(exp_ill));
    tick();
    chk({tag, ".wb_en_off"}, 32'(bus.wb_en),       32'd0);
    chk({tag, ".ready"},     32'(bus.instr_ready), 32'd1);
    chk({tag, ".hold"},      bus.wb_data,          exp);
    chk({tag, ".retired"},   32'(bus.retired),     32'(exp_ret));
    dbg({tag, ".dbg"}, rd, (rd == 5'd0) ? 32'd0 : exp);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
    bus.cfg_we      = 1'b0;
    bus.cfg_addr    = 5'd0;
    bus.cfg_data    = 32'd0;
    bus.dbg_addr    = 5'd0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst.ready",   32'(bus.instr_ready), 32'd1);
    chk("rst.busy",    32'(bus.busy),        32'd0);
    chk("rst.wb_en",   32'(bus.wb_en),       32'd0);
    chk("rst.illegal", 32'(bus.illegal),     32'd0);
    chk("rst.wb_addr", 32'(bus.wb_addr),     32'd0);
    chk("rst.wb_data", bus.wb_data,          32'd0);
    chk("rst.retired", 32'(bus.retired),     32'd0);
    dbg("rst.r5", 5'd5, 32'd0);

    cfg(5'd1, 32'd5);
    cfg(5'd2, 32'd3);
    run("add", rtype(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), 5'd3, 32'd8, 1'b0, 16'd1);

    cfg(5'd1, 32'd0);
    cfg(5'd2, 32'd1);
    run("sub", rtype(6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'b100010), 5'd4, 32'hFFFF_FFFF, 1'b0, 16'd2);

    cfg(5'd2, 32'h8000_0000);
    run("srl31", rtype(6'd0, 5'd0, 5'd2, 5'd5, 5'd31, 6'b000010), 5'd5, 32'd1, 1'b0, 16'd3);
    run("srl0",  rtype(6'd0, 5'd0, 5'd2, 5'd5, 5'd0,  6'b000010), 5'd5, 32'h8000_0000, 1'b0, 16'd4);

    cfg(5'd6, 32'd9);
    dbg("pre.r6", 5'd6, 32'd9);
    run("ill_funct", rtype(6'd0, 5'd1, 5'd2, 5'd6, 5'd0, 6'b111111), 5'd6, 32'd0, 1'b1, 16'd5);
    cfg(5'd8, 32'd44);
    run("ill_op", rtype(6'd1, 5'd1, 5'd2, 5'd8, 5'd0, 6'b100000), 5'd8, 32'd0, 1'b1, 16'd6);

    run("add_r0", rtype(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'b100000), 5'd0, 32'h8000_0000, 1'b0, 16'd7);
    cfg(5'd0, 32'd123);
    dbg("cfg.r0", 5'd0, 32'd0);
    cfg(5'd7, 32'd55);
    run("r0r0", rtype(6'd0, 5'd0, 5'd0, 5'd7, 5'd0, 6'b100000), 5'd7, 32'd0, 1'b0, 16'd8);

    // Back-to-back: second instruction reads r8 written by the first
    run("haz1", rtype(6'd0, 5'd3, 5'd3, 5'd8, 5'd0, 6'b100000), 5'd8, 32'd16, 1'b0, 16'd9);
    run("haz2", rtype(6'd0, 5'd8, 5'd3, 5'd9, 5'd0, 6'b100000), 5'd9, 32'd24, 1'b0, 16'd10);

    // cfg_we while busy is ignored
    bus.instr_valid = 1'b1;
    bus.instr       = rtype(6'd0, 5'd3, 5'd0, 5'd10, 5'd0, 6'b100000);
    tick();
    bus.instr_valid = 1'b0;
    bus.cfg_we      = 1'b1;
    bus.cfg_addr    = 5'd11;
    bus.cfg_data    = 32'hDEAD_BEEF;
    tick();
    tick();
    tick();
    bus.cfg_we = 1'b0;
    chk("busy_cfg.ready", 32'(bus.instr_ready), 32'd1);
    dbg("busy_cfg.r11", 5'd11, 32'd0);
    dbg("busy_cfg.r10", 5'd10, 32'd8);

    // cfg write on the accept edge feeds that instruction's READ
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 5'd13;
    bus.cfg_data = 32'd77;
    bus.cfg_we   = 1'b1;
    run("acc_cfg", rtype(6'd0, 5'd13, 5'd0, 5'd12, 5'd0, 6'b100000), 5'd12, 32'd77, 1'b0, 16'd12);
    bus.cfg_we = 1'b0;

    // Reset during EXEC aborts the instruction
    bus.instr_valid = 1'b1;
    bus.instr       = rtype(6'd0, 5'd3, 5'd3, 5'd14, 5'd0, 6'b100000);
    tick();
    bus.instr_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.ready",   32'(bus.instr_ready), 32'd1);
    chk("abort.wb_en",   32'(bus.wb_en),       32'd0);
    chk("abort.retired", 32'(bus.retired),     32'd0);
    tick();
    chk("abort.wb_en2",  32'(bus.wb_en),       32'd0);
    dbg("abort.r14", 5'd14, 32'd0);
    dbg("abort.r3",  5'd3,  32'd0);

    // Reset coinciding with cfg_we and an accept discards both
    cfg(5'd1, 32'd99);
    rst             = 1'b1;
    bus.cfg_we      = 1'b1;
    bus.cfg_addr    = 5'd2;
    bus.cfg_data    = 32'd42;
    bus.instr_valid = 1'b1;
    bus.instr       = rtype(6'd0, 5'd1, 5'd1, 5'd3, 5'd0, 6'b100000);
    tick();
    rst             = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.instr_valid = 1'b0;
    chk("prio.busy", 32'(bus.busy), 32'd0);
    dbg("prio.r1", 5'd1, 32'd0);
    dbg("prio.r2", 5'd2, 32'd0);

    // Continuous instr_valid: one accept every 4 cycles
    accepts         = 0;
    bus.instr_valid = 1'b1;
    bus.instr       = rtype(6'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'b100000);
    for (int i = 0; i < 12; i++) begin
      if (bus.instr_ready) accepts++;
      if (i == 5) chk("tput.ready_mid", 32'(bus.instr_ready), 32'd0);
      tick();
    end
    bus.instr_valid = 1'b0;
    chk("tput.accepts", 32'(accepts),     32'd3);
    chk("tput.retired", 32'(bus.retired), 32'd3);
    chk("tput.ready",   32'(bus.instr_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
